// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator with pixel/line counters, sync, blanking, de, strobes and frame counter
// Ports:
//   pclk, rst_n (async, active-low), ce (pixel enable)
//   hcount/vcount: raster position; hblnk/vblnk/de: blanking and data-enable
//   hsync/vsync: sync pulses of programmable polarity
//   line_start/frame_start: one-cycle strobes when the position wraps to 0
//   frame_cnt: completed-frame count
module vga_timing_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int CW        = 12,
    parameter int FCW       = 16
) (
    input  logic           pclk,
    input  logic           rst_n,
    input  logic           ce,
    output logic [CW-1:0]  hcount,
    output logic [CW-1:0]  vcount,
    output logic           hblnk,
    output logic           vblnk,
    output logic           de,
    output logic           hsync,
    output logic           vsync,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_params
        $error("vga_timing_gen: zero timing parameter or totals exceed counter width");
    end

    logic          h_wrap, v_wrap, step_line, step_frame;
    logic [CW-1:0] h_nxt, v_nxt;

    // Decode from next-state counters so every registered output matches the registered position.
    always_comb begin
        h_wrap     = hcount == H_LAST;
        v_wrap     = vcount == V_LAST;
        step_line  = ce && h_wrap;
        step_frame = step_line && v_wrap;
        h_nxt      = ce ? (h_wrap ? '0 : hcount + 1'b1) : hcount;
        v_nxt      = step_line ? (v_wrap ? '0 : vcount + 1'b1) : vcount;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            de          <= 1'b1;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hblnk       <= h_nxt >= H_ACT;
            vblnk       <= v_nxt >= V_ACT;
            de          <= h_nxt < H_ACT && v_nxt < V_ACT;
            hsync       <= (h_nxt >= H_SS && h_nxt < H_SE) ^ ~HSYNC_POL;
            vsync       <= (v_nxt >= V_SS && v_nxt < V_SE) ^ ~VSYNC_POL;
            line_start  <= step_line;
            frame_start <= step_frame;
            frame_cnt   <= step_frame ? frame_cnt + 1'b1 : frame_cnt;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a default-size and a tiny inverted-polarity timing generator against a per-cycle model
module tb_vga_timing_gen;
    logic        pclk = 1'b0;
    logic        rst_n, ce;
    logic [11:0] d_hc, d_vc, s_hc, s_vc;
    logic        d_hb, d_vb, d_de, d_hs, d_vs, d_ls, d_fs;
    logic        s_hb, s_vb, s_de, s_hs, s_vs, s_ls, s_fs;
    logic [15:0] d_fc;
    logic [1:0]  s_fc;
    logic [63:0] obs_d, obs_s;
    int          n_chk = 0, n_err = 0;
    int          dh, dv, dfc, sh, sv, sfc;
    bit          dls, dfs, sls, sfs;

    always #5 pclk = ~pclk;

    vga_timing_gen u_def (
        .pclk(pclk), .rst_n(rst_n), .ce(ce), .hcount(d_hc), .vcount(d_vc),
        .hblnk(d_hb), .vblnk(d_vb), .de(d_de), .hsync(d_hs), .vsync(d_vs),
        .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(12), .FCW(2)
    ) u_small (
        .pclk(pclk), .rst_n(rst_n), .ce(ce), .hcount(s_hc), .vcount(s_vc),
        .hblnk(s_hb), .vblnk(s_vb), .de(s_de), .hsync(s_hs), .vsync(s_vs),
        .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    assign obs_d = {24'd0, d_fc, d_vc, d_hc, d_hb, d_vb, d_de, d_hs, d_vs, d_ls, d_fs};
    assign obs_s = {24'd0, 16'(s_fc), s_vc, s_hc, s_hb, s_vb, s_de, s_hs, s_vs, s_ls, s_fs};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] expv(input int h, v, fc, input bit ls, fs,
                                         input int ha, hfp, hs, va, vfp, vs, input bit hp, vp);
        bit hb, vb, hsa, vsa;
        hb  = h >= ha;
        vb  = v >= va;
        hsa = h >= ha + hfp && h <= ha + hfp + hs - 1;
        vsa = v >= va + vfp && v <= va + vfp + vs - 1;
        return {24'd0, 16'(fc), 12'(v), 12'(h), hb, vb, !hb && !vb, hsa ? hp : !hp, vsa ? vp : !vp, ls, fs};
    endfunction

    task automatic adv(input int ht, vt, fm, inout int h, v, fc, output bit ls, fs);
        ls = 0;
        fs = 0;
        if (ce) begin
            if (h == ht - 1) begin
                h  = 0;
                ls = 1;
                if (v == vt - 1) begin
                    v  = 0;
                    fs = 1;
                    fc = (fc + 1) % fm;
                end else v++;
            end else h++;
        end
    endtask

    task automatic model_reset();
        dh = 0; dv = 0; dfc = 0; dls = 0; dfs = 0;
        sh = 0; sv = 0; sfc = 0; sls = 0; sfs = 0;
    endtask

    task automatic tick();
        @(posedge pclk);
        if (rst_n) begin
            adv(1056, 628, 65536, dh, dv, dfc, dls, dfs);
            adv(8, 6, 4, sh, sv, sfc, sls, sfs);
        end
        #1;
        check("def", obs_d, expv(dh, dv, dfc, dls, dfs, 800, 40, 128, 600, 1, 4, 1'b1, 1'b1));
        check("small", obs_s, expv(sh, sv, sfc, sls, sfs, 4, 1, 2, 3, 1, 1, 1'b0, 1'b0));
    endtask

    initial begin
        int first_ls, nls, nhs, hs_first, nfs, nls_s, seek;
        rst_n = 1'b0;
        ce    = 1'b0;
        model_reset();
        #12;
        check("reset_def", obs_d, 64'h10);
        check("reset_small", obs_s, 64'h1C);
        repeat (2) tick();
        rst_n = 1'b1;
        ce    = 1'b1;
        first_ls = -1; nls = 0; nhs = 0; hs_first = -1; nfs = 0;
        for (int i = 1; i <= 2112; i++) begin
            tick();
            if (d_ls && first_ls < 0) first_ls = i;
            if (d_ls) nls++;
            if (d_hs && i <= 1056) nhs++;
            if (d_hs && hs_first < 0) hs_first = int'(d_hc);
            if (s_fs) nfs++;
        end
        check("first_line_start", 64'(first_ls), 64'd1056);
        check("line_start_count", 64'(nls), 64'd2);
        check("hsync_width", 64'(nhs), 64'd128);
        check("hsync_first_h", 64'(hs_first), 64'd840);
        check("small_frames", 64'(nfs), 64'd44);
        check("line2_pos", {40'd0, d_vc, d_hc}, {40'd0, 12'd2, 12'd0});
        seek = 0;
        while (d_hc != 12'd500 && seek < 600) begin
            tick();
            seek++;
        end
        check("seek_h500", 64'(d_hc), 64'd500);
        rst_n = 1'b0;
        #2;
        check("async_rst_def", obs_d, 64'h10);
        check("async_rst_small", obs_s, 64'h1C);
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        nfs = 0; nls = 0; nls_s = 0;
        for (int i = 0; i < 400; i++) begin
            ce = (i % 2 == 0);
            tick();
            if (s_fs) nfs++;
            if (s_ls) nls_s++;
            if (d_ls || (s_ls && !ce)) nls++;
        end
        check("toggle_def_h", 64'(d_hc), 64'd200);
        check("toggle_small_frames", 64'(nfs), 64'd4);
        check("toggle_small_lines", 64'(nls_s), 64'd25);
        check("toggle_bad_strobes", 64'(nls), 64'd0);
        check("small_fc_wrapped", 64'(s_fc), 64'd0);
        ce = 1'b1;
        repeat (2112) tick();
        check("final_pos", {40'd0, d_vc, d_hc}, {40'd0, 12'd2, 12'd200});
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
